// File: rtl/ext_sched.sv
// ext_sched: two-requester round-robin scheduler feeding a
// zero/sign extension unit (8/16 -> 32 bit), one result per 3 cycles.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req_valid/req_ready   per-requester handshake (one-hot grant)
//   req0_data, req1_data  16-bit source operands
//   req_wsel, req_sign    per-requester width (1=16b) and sign mode
//   out_valid/out_ready   result handshake
//   out_data, out_tag     extended result and owning requester
//   busy                  high while a transaction is in flight
//   cnt0, cnt1            completion counts (EXT_SCHED_CNT_EN)
// Build option: define EXT_SCHED_CNT_EN to enable the counters.
module ext_sched #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [15:0]      req0_data,
  input  logic [15:0]      req1_data,
  input  logic [1:0]       req_wsel,
  input  logic [1:0]       req_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_tag,
  output logic             busy,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  logic [1:0]  state;
  logic        ptr;
  logic        tag_q;
  logic [15:0] dat_q;
  logic        wsel_q;
  logic        sign_q;
  logic [31:0] res_q;

  logic        gnt;
  logic        take;
  logic        hs;
  logic        fill8;
  logic        fill16;
  logic [31:0] ext;

  // A lone requester wins outright; ptr only breaks ties.
  always_comb begin
    gnt  = (req_valid == 2'b11) ? ptr : req_valid[1];
    take = rst_n && (state == IDLE) && (|req_valid);
    if (take)
      req_ready = gnt ? 2'b10 : 2'b01;
    else
      req_ready = 2'b00;
  end

  assign hs     = (state == OUT) && out_ready;
  assign fill8  = sign_q & dat_q[7];
  assign fill16 = sign_q & dat_q[15];

  always_comb begin
    ext = {{24{fill8}}, dat_q[7:0]};
    if (wsel_q)
      ext = {{16{fill16}}, dat_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= 1'b0;
      tag_q  <= 1'b0;
      dat_q  <= '0;
      wsel_q <= 1'b0;
      sign_q <= 1'b0;
      res_q  <= '0;
    end else begin
      unique case (1'b1)
        state == IDLE: begin
          if (take) begin
            state  <= EXEC;
            tag_q  <= gnt;
            dat_q  <= gnt ? req1_data : req0_data;
            wsel_q <= req_wsel[gnt];
            sign_q <= req_sign[gnt];
          end
        end
        state == EXEC: begin
          res_q <= ext;
          state <= OUT;
        end
        state == OUT: begin
          if (hs) begin
            ptr   <= ~tag_q;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = (state == OUT);
  assign busy      = (state == EXEC) || (state == OUT);
  assign out_data  = res_q;
  assign out_tag   = tag_q;

`ifdef EXT_SCHED_CNT_EN
  logic [CNT_W-1:0] c0_q;
  logic [CNT_W-1:0] c1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c0_q <= '0;
      c1_q <= '0;
    end else if (hs) begin
      if (tag_q)
        c1_q <= c1_q + CNT_W'(1);
      else
        c0_q <= c0_q + CNT_W'(1);
    end
  end

  assign cnt0 = c0_q;
  assign cnt1 = c1_q;
`else
  assign cnt0 = '0;
  assign cnt1 = '0;
`endif

endmodule
